// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter that lets NM pipelined Wishbone masters
// share one downstream slave. Ownership is registered and lasts until the owner
// drops CYC. While a master owns the bus, the downstream control and payload
// signals are taken combinationally from that master.
//
// Optional feature: define WB_RR_ARBITER_TIMEOUT_EN to add a watchdog. If a
// tenure hangs, the watchdog signals ERR to the owner and parks the arbiter in
// ABORT until the owner drops CYC.
//
// Ports
//   i_clk, i_reset_n        clock; synchronous active-low reset
//   i_m_cyc/stb/we          per-master Wishbone control, one bit per master
//   i_m_adr/dat/sel         per-master payload, master k at [k*W +: W]
//   o_m_ack/stall/err       per-master responses; non-owners see stall=1
//   o_grant                 one-hot current owner, 0 when idle (registered)
//   o_cyc/stb/we/adr/dat/sel  arbitrated downstream request
//   i_ack, i_stall, i_err   downstream slave responses
module wb_rr_arbiter #(
  parameter int unsigned NM    = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned LGTMO = 8,
  parameter int unsigned LGOUT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NM-1:0]        i_m_cyc,
  input  logic [NM-1:0]        i_m_stb,
  input  logic [NM-1:0]        i_m_we,
  input  logic [NM*AW-1:0]     i_m_adr,
  input  logic [NM*DW-1:0]     i_m_dat,
  input  logic [NM*DW/8-1:0]   i_m_sel,
  output logic [NM-1:0]        o_m_ack,
  output logic [NM-1:0]        o_m_stall,
  output logic [NM-1:0]        o_m_err,
  output logic [NM-1:0]        o_grant,
  output logic                 o_cyc,
  output logic                 o_stb,
  output logic                 o_we,
  output logic [AW-1:0]        o_adr,
  output logic [DW-1:0]        o_dat,
  output logic [DW/8-1:0]      o_sel,
  input  logic                 i_ack,
  input  logic                 i_stall,
  input  logic                 i_err
);

  localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    ,S_ABORT = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [NM-1:0]     grant_q, grant_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [LGOUT-1:0]  outst_q, outst_d;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic [LGTMO-1:0]  wd_q, wd_d;
  logic              timeout;
`endif

  logic [NM-1:0]     req;
  logic              win_any;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic              own_cyc, own_stb, sat, stb_gated, acc, rsp;

  assign req     = i_m_cyc & i_m_stb;
  assign own_cyc = i_m_cyc[owner_q];
  assign own_stb = i_m_stb[owner_q];
  assign sat     = (outst_q == {LGOUT{1'b1}});

  // Payload always follows the owner; it is only meaningful while o_cyc is high.
  assign o_we    = i_m_we[owner_q];
  assign o_adr   = i_m_adr[owner_q*AW +: AW];
  assign o_dat   = i_m_dat[owner_q*DW +: DW];
  assign o_sel   = i_m_sel[owner_q*SW +: SW];
  assign o_grant = grant_q;

  // Round-robin pick: first requester above the pointer, wrapping mod NM.
  // The loop runs from the farthest candidate down so the nearest one wins.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = NM; i >= 1; i--) begin
      cand = PW'((32'(ptr_q) + i) % NM);
      if (req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and bus-steering logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    outst_d   = outst_q;
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_m_ack   = '0;
    o_m_err   = '0;
    o_m_stall = '1;
    stb_gated = 1'b0;
    acc       = 1'b0;
    rsp       = 1'b0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    wd_d      = '0;
    timeout   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        outst_d = '0;
        if (win_any) begin
          state_d = S_OWN;
          grant_d = NM'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx;
        end
      end
      S_OWN: begin
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        timeout = (wd_q == {LGTMO{1'b1}});
`endif
        // Hold STB off while the outstanding counter is full so the slave never
        // accepts a beat the owner still believes is stalled.
        stb_gated          = own_cyc & own_stb & ~sat;
        o_cyc              = own_cyc;
        o_stb              = stb_gated;
        o_m_stall[owner_q] = i_stall | sat;
        o_m_ack[owner_q]   = i_ack;
        o_m_err[owner_q]   = i_err;
        acc = stb_gated & ~i_stall;
        rsp = (i_ack | i_err) & (outst_q != '0);
        if (acc && !rsp)      outst_d = outst_q + 1'b1;
        else if (rsp && !acc) outst_d = outst_q - 1'b1;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        if (timeout) begin
          o_m_ack[owner_q] = 1'b0;
          o_m_err[owner_q] = 1'b1;
        end
        if (outst_q == '0 || i_ack || i_err) wd_d = '0;
        else if (!timeout)                   wd_d = wd_q + 1'b1;
`endif
        if (!own_cyc) begin
          state_d = S_IDLE;
          grant_d = '0;
          outst_d = '0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        end else if (timeout) begin
          state_d = S_ABORT;
`endif
        end
      end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      // Bus released downstream; owner is held stalled until it gives up CYC.
      S_ABORT: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          grant_d = '0;
          outst_d = '0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        outst_d = '0;
      end
    endcase
  end

  // State register; reset parks the pointer at NM-1 so master 0 wins first.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(NM - 1);
      outst_q <= '0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      outst_q <= outst_d;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter. The grant order is predicted by a priority-list
// model: the list starts as 0..NM-1, and each winner is rotated to the back.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_wb_rr_arbiter;
  localparam int unsigned NM = 4, AW = 32, DW = 32, LGTMO = 4, LGOUT = 4;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [NM-1:0]    m_cyc, m_stb, m_we, m_ack, m_stall, m_err, grant;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic             cyc, stb, we, s_ack, s_stall, s_err;
  logic [AW-1:0]    adr;
  logic [DW-1:0]    dat;
  logic [SW-1:0]    sel;

  int n_vec = 0;
  int n_bad = 0;
  int order_q[$];

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .LGTMO(LGTMO), .LGOUT(LGOUT)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_ack(m_ack), .o_m_stall(m_stall), .o_m_err(m_err), .o_grant(grant),
    .o_cyc(cyc), .o_stb(stb), .o_we(we), .o_adr(adr), .o_dat(dat), .o_sel(sel),
    .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NM; k++) begin
      m_adr[k*AW +: AW] = $urandom;
      m_dat[k*DW +: DW] = $urandom;
      m_sel[k*SW +: SW] = SW'($urandom);
    end
    m_we = NM'($urandom);
  endtask

  task automatic model_reset();
    order_q = {};
    for (int k = 0; k < NM; k++) order_q.push_back(k);
  endtask

  // Highest-priority requester in the current priority list.
  function automatic int model_pick(input logic [NM-1:0] p);
    foreach (order_q[i]) if (p[order_q[i]]) return order_q[i];
    return -1;
  endfunction

  // Winner drops to lowest priority; the cyclic order is preserved.
  task automatic model_grant(input int w);
    while (order_q[0] != w) order_q.push_back(order_q.pop_front());
    order_q.push_back(order_q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_idle();
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rand_payload();
    m_cyc = '1; m_stb = '1; s_ack = 1'b1; s_err = 1'b1; s_stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      n_vec++;
      if ({grant, cyc, stb, m_ack, m_err, m_stall} !== {NM'(0), 1'b0, 1'b0, NM'(0), NM'(0), {NM{1'b1}}}) begin
        n_bad++;
        $display("FAIL reset: grant=%b cyc=%b stb=%b ack=%b err=%b stall=%b, required 0000 0 0 0000 0000 1111",
                 grant, cyc, stb, m_ack, m_err, m_stall);
      end
    end
    do_reset();
  endtask

  task automatic test_first_grant();
    logic [NM-1:0] exp_st;
    do_reset();
    rand_payload();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    settle();
    n_vec++;
    if ({grant, cyc, m_stall[0]} !== {NM'(0), 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL first_req_cycle: grant=%b cyc=%b stall0=%b, required 0000 0 1", grant, cyc, m_stall[0]);
    end
    tick();
    s_stall = 1'($urandom_range(1, 0));
    settle();
    exp_st = '1; exp_st[0] = s_stall;
    n_vec++;
    if ({grant, cyc, stb, we, adr, dat, sel, m_stall} !==
        {NM'(1), 1'b1, 1'b1, m_we[0], m_adr[0 +: AW], m_dat[0 +: DW], m_sel[0 +: SW], exp_st}) begin
      n_bad++;
      $display("FAIL first_grant: grant=%b cyc=%b stb=%b adr=%h stall=%b, required 0001 1 1 %h %b",
               grant, cyc, stb, adr, m_stall, m_adr[0 +: AW], exp_st);
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_rr_order();
    logic [NM-1:0] pend, exp_g, exp_st;
    int w;
    do_reset();
    pend = '0;
    for (int t = 0; t < 24; t++) begin
      rand_payload();
      if (t < 5) pend = '1;
      else       pend |= NM'($urandom);
      if (pend == '0) pend[$urandom_range(NM - 1, 0)] = 1'b1;
      m_cyc = pend; m_stb = pend;
      w = model_pick(pend);
      exp_g = '0; exp_g[w] = 1'b1;
      settle();
      n_vec++;
      if ({grant, cyc} !== {NM'(0), 1'b0}) begin
        n_bad++;
        $display("FAIL rr_idle_gap t=%0d: grant=%b cyc=%b, required 0000 0", t, grant, cyc);
      end
      tick();
      settle();
      exp_st = ~exp_g;
      n_vec++;
      if ({grant, cyc, stb, adr, m_stall} !== {exp_g, 1'b1, 1'b1, m_adr[w*AW +: AW], exp_st}) begin
        n_bad++;
        $display("FAIL rr_grant t=%0d: grant=%b cyc=%b stb=%b stall=%b, required %b 1 1 %b",
                 t, grant, cyc, stb, m_stall, exp_g, exp_st);
      end
      model_grant(w);
      tick();
      s_ack = 1'b1;
      settle();
      n_vec++;
      if ({m_ack, m_err} !== {exp_g, NM'(0)}) begin
        n_bad++;
        $display("FAIL rr_ack1 t=%0d: ack=%b err=%b, required %b 0000", t, m_ack, m_err, exp_g);
      end
      tick();
      m_stb[w] = 1'b0;
      settle();
      n_vec++;
      if ({m_ack, stb} !== {exp_g, 1'b0}) begin
        n_bad++;
        $display("FAIL rr_ack2 t=%0d: ack=%b stb=%b, required %b 0", t, m_ack, stb, exp_g);
      end
      tick();
      s_ack = 1'b0;
      m_cyc[w] = 1'b0;
      pend[w] = 1'b0;
      settle();
      n_vec++;
      if ({cyc, grant} !== {1'b0, exp_g}) begin
        n_bad++;
        $display("FAIL rr_drop t=%0d: cyc=%b grant=%b, required 0 %b", t, cyc, grant, exp_g);
      end
      tick();
    end
    bus_idle();
    tick();
  endtask

  task automatic test_hold();
    logic [NM-1:0] exp_a;
    do_reset();
    rand_payload();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    settle();
    n_vec++;
    if (grant !== NM'(4)) begin
      n_bad++;
      $display("FAIL hold_grant2: grant=%b, required 0100", grant);
    end
    tick();
    m_stb[2] = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_ack = (i == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      settle();
      exp_a = '0; exp_a[2] = s_ack;
      n_vec++;
      if ({grant, m_stall[1], m_ack, adr} !== {NM'(4), 1'b1, exp_a, m_adr[2*AW +: AW]}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: grant=%b stall1=%b ack=%b adr=%h, required 0100 1 %b %h",
                 i, grant, m_stall[1], m_ack, adr, exp_a, m_adr[2*AW +: AW]);
      end
      tick();
    end
    s_ack = 1'b0;
    m_cyc[2] = 1'b0;
    tick();
    settle();
    n_vec++;
    if ({grant, cyc} !== {NM'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL hold_gap: grant=%b cyc=%b, required 0000 0", grant, cyc);
    end
    tick();
    settle();
    n_vec++;
    if ({grant, adr} !== {NM'(2), m_adr[AW +: AW]}) begin
      n_bad++;
      $display("FAIL hold_handover: grant=%b adr=%h, required 0010 %h", grant, adr, m_adr[AW +: AW]);
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_outstanding();
    logic [NM-1:0] exp_a, exp_st;
    int acc = 0, owed = 0, seen = 0, gap = 0, cyc_n = 0;
    do_reset();
    rand_payload();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    while (!(acc == 3 && owed == 0) && cyc_n < 200) begin
      m_stb[0] = (acc < 3);
      s_stall  = 1'($urandom_range(1, 0));
      s_ack    = (owed > 0) && (1'($urandom_range(1, 0)) || gap >= 3);
      for (int k = 1; k < NM; k++) begin
        m_cyc[k] = 1'($urandom_range(1, 0));
        m_stb[k] = m_cyc[k];
      end
      settle();
      exp_a  = '0; exp_a[0] = s_ack;
      exp_st = '1; exp_st[0] = s_stall;
      n_vec++;
      if ({m_ack, m_stall, stb, grant} !== {exp_a, exp_st, m_stb[0], NM'(1)}) begin
        n_bad++;
        $display("FAIL outst_cycle%0d: ack=%b stall=%b stb=%b grant=%b, required %b %b %b 0001",
                 cyc_n, m_ack, m_stall, stb, grant, exp_a, exp_st, m_stb[0]);
      end
      if (m_ack[0]) seen++;
      if (m_stb[0] && !s_stall) begin acc++; owed++; end
      if (s_ack) begin owed--; gap = 0; end
      else if (owed > 0) gap++;
      cyc_n++;
      tick();
    end
    n_vec++;
    if (cyc_n >= 200 || seen != 3) begin
      n_bad++;
      $display("FAIL outst_acks: ack pulses=%0d cycles=%0d, required 3 pulses within 200", seen, cyc_n);
    end
    bus_idle();
    tick();
    tick();
  endtask

`ifndef WB_RR_ARBITER_TIMEOUT_EN
  task automatic test_saturate();
    int acc = 0;
    logic exp_st;
    do_reset();
    rand_payload();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      settle();
      exp_st = (acc >= (1 << LGOUT) - 1);
      n_vec++;
      if (m_stall[1] !== exp_st) begin
        n_bad++;
        $display("FAIL sat_cycle%0d: stall1=%b, required %b (accepted %0d)", i, m_stall[1], exp_st, acc);
      end
      if (!exp_st) acc++;
      tick();
    end
    m_stb[1] = 1'b0;
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    settle();
    n_vec++;
    if (m_stall[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_release: stall1=%b, required 0", m_stall[1]);
    end
    bus_idle();
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    rand_payload();
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    tick();
    settle();
    n_vec++;
    if (grant !== NM'(8)) begin
      n_bad++;
      $display("FAIL rmid_grant3: grant=%b, required 1000", grant);
    end
    tick();
    tick();
    m_stb[3] = 1'b0;
    rst_n = 1'b0;
    m_cyc = '1; m_stb = '1;
    tick();
    rst_n = 1'b1;
    model_reset();
    settle();
    n_vec++;
    if ({grant, cyc, m_stall} !== {NM'(0), 1'b0, {NM{1'b1}}}) begin
      n_bad++;
      $display("FAIL rmid_reset: grant=%b cyc=%b stall=%b, required 0000 0 1111", grant, cyc, m_stall);
    end
    tick();
    settle();
    n_vec++;
    if (grant !== NM'(1) << model_pick(m_cyc & m_stb)) begin
      n_bad++;
      $display("FAIL rmid_contest: grant=%b, required 0001", grant);
    end
    bus_idle();
    tick();
    tick();
  endtask

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic [NM-1:0] exp_e;
    do_reset();
    rand_payload();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    settle();
    n_vec++;
    if ({grant, stb} !== {NM'(2), 1'b1}) begin
      n_bad++;
      $display("FAIL tmo_grant: grant=%b stb=%b, required 0010 1", grant, stb);
    end
    tick();
    m_stb[1] = 1'b0;
    for (int k = 1; k <= (1 << LGTMO); k++) begin
      settle();
      exp_e = '0; exp_e[1] = (k == (1 << LGTMO));
      n_vec++;
      if ({m_err, m_ack, cyc} !== {exp_e, NM'(0), 1'b1}) begin
        n_bad++;
        $display("FAIL tmo_wait%0d: err=%b ack=%b cyc=%b, required %b 0000 1", k, m_err, m_ack, cyc, exp_e);
      end
      tick();
    end
    s_ack = 1'b1;
    settle();
    n_vec++;
    if ({cyc, stb, m_ack, m_err, m_stall[1]} !== {1'b0, 1'b0, NM'(0), NM'(0), 1'b1}) begin
      n_bad++;
      $display("FAIL tmo_abort: cyc=%b stb=%b ack=%b err=%b stall1=%b, required 0 0 0000 0000 1",
               cyc, stb, m_ack, m_err, m_stall[1]);
    end
    tick();
    s_ack = 1'b0;
    m_cyc[1] = 1'b0;
    tick();
    settle();
    n_vec++;
    if (grant !== NM'(0)) begin
      n_bad++;
      $display("FAIL tmo_release: grant=%b, required 0000", grant);
    end
    bus_idle();
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus_idle();
    rand_payload();
    model_reset();
    test_reset();
    test_first_grant();
    test_rr_order();
    test_hold();
    test_outstanding();
`ifndef WB_RR_ARBITER_TIMEOUT_EN
    test_saturate();
`endif
    test_reset_mid();
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
